// File: rtl/limber_gnrl_fcs_append_pkg.sv
// Shared definitions for the Ethernet TX FCS append controller.
// - state_e        : controller FSM encoding
// - CRC32_INIT     : CRC register seed (all ones)
// - CRC32_POLY     : reflected CRC-32 polynomial
// - crc32_byte     : one byte of reflected (LSB-first) CRC-32 update
// - bitrev32       : 32-bit bit reversal
package limber_gnrl_fcs_append_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAD  = 2'd2,
    ST_FCS  = 2'd3
  } state_e;

  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY      = 32'hEDB8_8320;
  localparam int unsigned ETH_MIN_PAYLOAD = 60;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/limber_gnrl_crc32.sv
// Byte-wide CRC-32 engine (IEEE 802.3 polynomial, reflected, seed all ones).
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_clr         : reload the seed (has priority over i_data_vld)
//   i_data_vld    : fold i_data into the running CRC this cycle
//   i_data        : input byte, consumed LSB first
//   o_crc_data    : running CRC register, bit-reversed (MSB-first view)
module limber_gnrl_crc32
  import limber_gnrl_fcs_append_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_clr,
  input  logic        i_data_vld,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc_data
);

  logic [31:0] crc_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      crc_q <= CRC32_INIT;
    end else if (i_clr) begin
      crc_q <= CRC32_INIT;
    end else if (i_data_vld) begin
      crc_q <= crc32_byte(crc_q, i_data);
    end
  end

  assign o_crc_data = bitrev32(crc_q);

endmodule

// File: rtl/limber_gnrl_fcs_append.sv
// Ethernet TX FCS append controller. Passes payload bytes through with no
// added latency, zero-pads frames shorter than MIN_LEN bytes, then appends
// the 4-byte FCS least-significant byte first with m_last on the final byte.
// Ports:
//   i_clk, i_rstn              : clock, asynchronous active-low reset
//   s_data/s_valid/s_last/s_ready : upstream payload stream
//   m_data/m_valid/m_last/m_ready : downstream byte stream
//   o_busy                     : controller is not idle
//   o_frm_done                 : one-cycle pulse after the final FCS byte transfers
module limber_gnrl_fcs_append
  import limber_gnrl_fcs_append_pkg::*;
#(
  parameter int unsigned MIN_LEN = ETH_MIN_PAYLOAD,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       o_busy,
  output logic       o_frm_done
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic [1:0]         idx_q;
  logic               frm_done_q;
  logic               min_reached;
  logic               s_xfer;
  logic               m_xfer;
  logic               crc_clr;
  logic               crc_vld;
  logic [7:0]         crc_din;
  logic [31:0]        crc_out;
  logic [31:0]        fcs;

  limber_gnrl_crc32 u_crc32 (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_clr      (crc_clr),
    .i_data_vld (crc_vld),
    .i_data     (crc_din),
    .o_crc_data (crc_out)
  );

  // Saturating count; once pinned at all-ones the frame is never padded.
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign min_reached = 32'(cnt_inc) >= MIN_LEN;

  assign s_xfer = s_valid & s_ready;
  assign m_xfer = m_valid & m_ready;

  // The engine neither clears nor updates while in FCS, so its output is the
  // snapshot taken on entry. Undo the engine's bit reversal, then complement.
  assign fcs = ~bitrev32(crc_out);

  assign crc_clr = (state_q == ST_IDLE);
  assign crc_vld = ((state_q == ST_DATA) & s_xfer) | ((state_q == ST_PAD) & m_xfer);
  assign crc_din = (state_q == ST_DATA) ? s_data : 8'h00;

  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = 8'h00;
    unique case (state_q)
      ST_IDLE: ;
      ST_DATA: begin
        s_ready = m_ready;
        m_valid = s_valid;
        m_data  = s_data;
      end
      ST_PAD: begin
        m_valid = 1'b1;
      end
      ST_FCS: begin
        m_valid = 1'b1;
        m_last  = (idx_q == 2'd3);
        unique case (idx_q)
          2'd0: m_data = fcs[7:0];
          2'd1: m_data = fcs[15:8];
          2'd2: m_data = fcs[23:16];
          2'd3: m_data = fcs[31:24];
        endcase
      end
    endcase
  end

  assign o_busy     = (state_q != ST_IDLE);
  assign o_frm_done = frm_done_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      frm_done_q <= 1'b0;
    end else begin
      frm_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          idx_q <= 2'd0;
          if (s_valid) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (s_xfer) begin
            cnt_q <= cnt_inc;
            if (s_last) state_q <= min_reached ? ST_FCS : ST_PAD;
          end
        end
        ST_PAD: begin
          if (m_xfer) begin
            cnt_q <= cnt_inc;
            if (min_reached) state_q <= ST_FCS;
          end
        end
        ST_FCS: begin
          if (m_xfer) begin
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_q    <= ST_IDLE;
              frm_done_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_limber_gnrl_fcs_append.sv
module tb_limber_gnrl_fcs_append;

  logic       i_clk   = 1'b0;
  logic       i_rstn  = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last  = 1'b0;
  logic       m_ready = 1'b1;
  logic       sel     = 1'b0;  // 0: MIN_LEN=0 instance, 1: MIN_LEN=60 instance
  logic       rnd_mode = 1'b0;

  logic       s_ready_a, m_valid_a, m_last_a, busy_a, done_a;
  logic [7:0] m_data_a;
  logic       s_ready_b, m_valid_b, m_last_b, busy_b, done_b;
  logic [7:0] m_data_b;

  logic       s_ready_m, m_valid_m, m_last_m, done_m, m_ready_m;
  logic [7:0] m_data_m;

  int checks   = 0;
  int failures = 0;
  int frm_cnt  = 0;
  int cyc      = 0;

  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] out_q[$];
  logic       last_q[$];
  int         hs_q[$];

  logic       hold_pending = 1'b0;
  logic [8:0] hold_val     = 9'h0;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  always @(posedge i_clk) begin
    #1;
    m_ready = rnd_mode ? 1'($urandom_range(1)) : 1'b1;
  end

  limber_gnrl_fcs_append #(.MIN_LEN(0), .CNT_W(16)) u_dut_a (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .s_data     (s_data),
    .s_valid    (s_valid & ~sel),
    .s_last     (s_last),
    .s_ready    (s_ready_a),
    .m_data     (m_data_a),
    .m_valid    (m_valid_a),
    .m_last     (m_last_a),
    .m_ready    (sel ? 1'b1 : m_ready),
    .o_busy     (busy_a),
    .o_frm_done (done_a)
  );

  limber_gnrl_fcs_append #(.MIN_LEN(60), .CNT_W(16)) u_dut_b (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .s_data     (s_data),
    .s_valid    (s_valid & sel),
    .s_last     (s_last),
    .s_ready    (s_ready_b),
    .m_data     (m_data_b),
    .m_valid    (m_valid_b),
    .m_last     (m_last_b),
    .m_ready    (sel ? m_ready : 1'b1),
    .o_busy     (busy_b),
    .o_frm_done (done_b)
  );

  assign s_ready_m = sel ? s_ready_b : s_ready_a;
  assign m_valid_m = sel ? m_valid_b : m_valid_a;
  assign m_last_m  = sel ? m_last_b  : m_last_a;
  assign m_data_m  = sel ? m_data_b  : m_data_a;
  assign done_m    = sel ? done_b    : done_a;
  assign m_ready_m = m_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, a handshake seen here
  // completes on the next rising edge.
  always @(negedge i_clk) begin
    if (!i_rstn) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending)
        chk("hold_stable", {23'h0, m_valid_m, m_last_m, m_data_m}, {23'h0, 1'b1, hold_val});
      if (m_valid_m && m_ready_m) begin
        out_q.push_back(m_data_m);
        last_q.push_back(m_last_m);
        hs_q.push_back(cyc);
      end
      if (done_m) frm_cnt++;
      hold_pending = m_valid_m && !m_ready_m;
      hold_val     = {m_last_m, m_data_m};
    end
  end

  // Bit-serial reference CRC-32 over exp_q, complemented.
  function automatic logic [31:0] ref_fcs();
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (exp_q[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ exp_q[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic build_exp(input int min_len);
    logic [31:0] f;
    exp_q = pay_q;
    while (exp_q.size() < min_len) exp_q.push_back(8'h00);
    f = ref_fcs();
    exp_q.push_back(f[7:0]);
    exp_q.push_back(f[15:8]);
    exp_q.push_back(f[23:16]);
    exp_q.push_back(f[31:24]);
  endtask

  task automatic start_test();
    out_q.delete();
    last_q.delete();
    hs_q.delete();
    frm_cnt = 0;
  endtask

  task automatic send_frame(input bit gaps);
    int t;
    foreach (pay_q[i]) begin
      if (gaps && $urandom_range(2) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(3, 1)) begin
          @(posedge i_clk);
          #1;
        end
      end
      s_valid = 1'b1;
      s_data  = pay_q[i];
      s_last  = (i == pay_q.size() - 1);
      t = 0;
      do begin
        @(negedge i_clk);
        t++;
      end while (!s_ready_m && t < 300);
      if (!s_ready_m) chk("s_ready_timeout", 32'(s_ready_m), 32'd1);
      @(posedge i_clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (frm_cnt < target && t < 3000) begin
      @(posedge i_clk);
      #2;
      t++;
    end
    chk("frame_done_seen", 32'(frm_cnt >= target), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int nfr, input int flen);
    wait_done(nfr);
    @(posedge i_clk);
    #2;
    chk({tag, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
    chk({tag, "_done_cnt"}, 32'(frm_cnt), 32'(nfr));
    chk({tag, "_busy_end"}, 32'(sel ? busy_b : busy_a), 32'd0);
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'((i % flen) == flen - 1));
    end
  endtask

  task automatic load_123456789();
    pay_q.delete();
    for (int i = 0; i < 9; i++) pay_q.push_back(8'(8'h31 + i));
  endtask

  task automatic exp_123456789();
    exp_q = pay_q;
    exp_q.push_back(8'h26);
    exp_q.push_back(8'h39);
    exp_q.push_back(8'hF4);
    exp_q.push_back(8'hCB);
  endtask

  initial begin
    int t;
    // Reset state
    #1;
    chk("rst_s_ready", 32'(s_ready_a), 32'd0);
    chk("rst_m_valid", 32'(m_valid_a), 32'd0);
    chk("rst_m_last", 32'(m_last_a), 32'd0);
    chk("rst_m_data", 32'(m_data_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_frm_done", 32'(done_a), 32'd0);
    chk("rst_b_m_valid", 32'(m_valid_b), 32'd0);
    #20;
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;

    // "123456789", no padding
    sel = 1'b0;
    start_test();
    load_123456789();
    send_frame(1'b0);
    exp_123456789();
    check_frame("a", 1, 13);

    // Same frame padded to 60
    sel = 1'b1;
    start_test();
    load_123456789();
    send_frame(1'b0);
    build_exp(60);
    check_frame("b", 1, 64);

    // Exactly 60-byte frame: no padding
    start_test();
    pay_q.delete();
    for (int i = 0; i < 60; i++) pay_q.push_back(8'(i * 7 + 3));
    send_frame(1'b0);
    build_exp(60);
    check_frame("c", 1, 64);

    // 100 bytes with random backpressure and source gaps
    sel = 1'b0;
    rnd_mode = 1'b1;
    start_test();
    pay_q.delete();
    for (int i = 0; i < 100; i++) pay_q.push_back(8'($urandom_range(255)));
    send_frame(1'b1);
    build_exp(0);
    check_frame("d", 1, 104);
    rnd_mode = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;

    // Back-to-back single 0x00 frames
    start_test();
    pay_q.delete();
    pay_q.push_back(8'h00);
    send_frame(1'b0);
    send_frame(1'b0);
    exp_q.delete();
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h8D);
      exp_q.push_back(8'hEF);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'hD2);
    end
    check_frame("e", 2, 5);
    if (hs_q.size() >= 6) chk("e_idle_gap", 32'(hs_q[5] - hs_q[4]), 32'd2);
    else chk("e_hs_count", 32'(hs_q.size()), 32'd10);

    // Reset in the middle of the FCS bytes
    start_test();
    load_123456789();
    send_frame(1'b0);
    t = 0;
    while (out_q.size() < 11 && t < 100) begin
      @(posedge i_clk);
      #2;
      t++;
    end
    chk("f_reach_fcs", 32'(out_q.size() >= 11), 32'd1);
    i_rstn = 1'b0;
    #1;
    chk("f_rst_s_ready", 32'(s_ready_a), 32'd0);
    chk("f_rst_m_valid", 32'(m_valid_a), 32'd0);
    chk("f_rst_m_last", 32'(m_last_a), 32'd0);
    chk("f_rst_m_data", 32'(m_data_a), 32'd0);
    chk("f_rst_busy", 32'(busy_a), 32'd0);
    chk("f_rst_frm_done", 32'(done_a), 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
    start_test();
    load_123456789();
    send_frame(1'b0);
    exp_123456789();
    check_frame("f", 1, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
